// File: rtl/seg_display_ctrl_if.sv
// Display-register side of the seven-segment controller: load handshake, status and
// multiplexed digit outputs.
interface seg_display_ctrl_if;
    logic        load;
    logic [13:0] value;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  digit_out;
    logic [3:0]  an;

    modport master (
        output load, value,
        input  busy, done, ovf, digit_out, an
    );

    modport slave (
        input  load, value,
        output busy, done, ovf, digit_out, an
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// Four-digit multiplexed seven-segment controller: sequential double-dabble binary-to-BCD,
// atomic commit to a display register, and a leading-zero-blanked digit scanner.
module seg_display_ctrl #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    seg_display_ctrl_if.slave bus
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
    localparam logic [13:0] MaxVal = 14'd9999;

    typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

    state_e      state_q, state_d;
    logic [13:0] shift_q, shift_d;
    logic [15:0] scratch_q, scratch_d;
    logic [15:0] scratch_adj;
    logic [3:0]  iter_q, iter_d;
    logic [15:0] disp_q, disp_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    logic [CntW-1:0] refresh_q, refresh_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      an_q, an_d;
    logic [3:0]      digit_q, digit_d;
    logic [3:0]      blank;

    // Add-3 correction applied to every scratch nibble before each shift
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        ovf_d     = ovf_q;
        disp_d    = disp_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.load) begin
                    shift_d   = (bus.value > MaxVal) ? MaxVal : bus.value;
                    ovf_d     = (bus.value > MaxVal);
                    scratch_d = '0;
                    iter_d    = '0;
                    state_d   = StConv;
                end
            end
            StConv: begin
                {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd13) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                disp_d  = scratch_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Scanner runs freely; outputs are recomputed from next-state so they move
    // only on a terminal count or a commit, and never lag the display register.
    always_comb begin
        refresh_d = (refresh_q == CntLast) ? '0 : refresh_q + 1'b1;
        idx_d     = (refresh_q == CntLast) ? idx_q + 2'd1 : idx_q;
        blank     = {disp_d[15:12] == 4'h0, disp_d[15:8] == 8'h0, disp_d[15:4] == 12'h0, 1'b0};
        digit_d   = disp_d[{idx_d, 2'b00} +: 4];
        an_d      = blank[idx_d] ? 4'b1111 : ~(4'b0001 << idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            refresh_q <= '0;
            idx_q     <= '0;
            an_q      <= 4'b1110;
            digit_q   <= 4'h0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            iter_q    <= iter_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            digit_q   <= digit_d;
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.ovf       = ovf_q;
    assign bus.digit_out = digit_q;
    assign bus.an        = an_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: stimulus pushes expected BCD/ovf, a monitor pops on
// each done pulse and checks one full scan frame.
module tb_seg_display_ctrl;

    localparam int unsigned Div = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_display_ctrl_if bus();

    seg_display_ctrl #(.REFRESH_DIV(Div)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int total = 0;
    int bad = 0;
    int done_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] bcd, input logic ovf);
        exp_t e;
        e.bcd = bcd;
        e.ovf = ovf;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [13:0] v);
        @(negedge clk);
        bus.load  = 1'b1;
        bus.value = v;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic wait_idle(input int exp_busy);
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy_len", n, exp_busy);
        repeat (20) @(negedge clk);
    endtask

    // Monitor: one frame (4*Div cycles) starting in the done cycle
    initial begin
        exp_t e;
        int   hits[4];
        int   blanks;
        int   nblank;
        logic [3:0] nib;
        forever begin
            @(negedge clk);
            if (!rst && bus.done) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse");
                end else begin
                    e = sb_q.pop_front();
                    done_seen++;
                    check("ovf", int'(bus.ovf), int'(e.ovf));
                    for (int k = 0; k < 4; k++) hits[k] = 0;
                    blanks = 0;
                    for (int c = 0; c < 4 * Div; c++) begin
                        if (c == 1) check("done_width", int'(bus.done), 0);
                        if (bus.an == 4'b1111) blanks++;
                        for (int k = 0; k < 4; k++) begin
                            nib = 4'((e.bcd >> (4 * k)) & 16'hf);
                            if (bus.an == ~(4'b0001 << k) && bus.digit_out == nib) hits[k]++;
                        end
                        if (c < 4 * Div - 1) @(negedge clk);
                    end
                    nblank = 0;
                    for (int k = 0; k < 4; k++) begin
                        if (k > 0 && (e.bcd >> (4 * k)) == 16'h0) begin
                            nblank++;
                            check($sformatf("digit%0d_blank", k), hits[k], 0);
                        end else begin
                            check($sformatf("digit%0d_slot", k), hits[k], Div);
                        end
                    end
                    check("blank_cycles", blanks, nblank * Div);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.load  = 1'b0;
        bus.value = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_ovf", int'(bus.ovf), 0);
        check("rst_an", int'(bus.an), 4'he);
        check("rst_digit", int'(bus.digit_out), 0);
        rst = 1'b0;

        // Idle after reset: only the ones digit lit, showing 0
        for (int c = 0; c < 4 * Div; c++) begin
            check($sformatf("idle_an%0d", c), int'(bus.an), (c < Div) ? 4'he : 4'hf);
            check($sformatf("idle_digit%0d", c), int'(bus.digit_out), 0);
            @(negedge clk);
        end

        push(16'h1234, 1'b0); issue(14'd1234);  wait_idle(15);
        push(16'h9999, 1'b1); issue(14'd12000); wait_idle(15);
        push(16'h0007, 1'b0); issue(14'd7);     wait_idle(15);

        // Second load lands at E5 and must be dropped
        push(16'h0005, 1'b0);
        issue(14'd5);
        repeat (4) @(negedge clk);
        bus.load  = 1'b1;
        bus.value = 14'd9000;
        @(negedge clk);
        bus.load  = 1'b0;
        wait_idle(10);

        push(16'h0305, 1'b0); issue(14'd305); wait_idle(15);

        // Abort a conversion with reset at E8; no done may follow
        issue(14'd4321);
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_ovf", int'(bus.ovf), 0);
        check("abort_an", int'(bus.an), 4'he);
        check("abort_digit", int'(bus.digit_out), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        push(16'h0042, 1'b0); issue(14'd42); wait_idle(15);

        repeat (20) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        check("done_count", done_seen, 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
